// File: rtl/vga_pkg.sv
// Shared 640x480@60 video timing constants and colour-bar helpers.
// Reused by the VGA generator and other video blocks (e.g. an HDMI wrapper).
package vga_pkg;

  // Horizontal timing, in pixels.
  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;  // 800

  // Vertical timing, in lines.
  localparam int V_ACTIVE = 480;
  localparam int V_FP     = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 33;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;  // 525

  // Datapath widths and pattern geometry.
  localparam int CNT_W     = 12;
  localparam int COORD_W   = 10;
  localparam int COLOR_W   = 8;
  localparam int BAR_WIDTH = 80;  // 640 / 8 bars

  typedef logic [CNT_W-1:0] count_t;

  typedef struct packed {
    logic [COLOR_W-1:0] red;
    logic [COLOR_W-1:0] green;
    logic [COLOR_W-1:0] blue;
  } rgb_t;

  // Bar index bits map straight onto the primaries, which yields the
  // classic order black, blue, green, cyan, red, magenta, yellow, white.
  function automatic rgb_t bar_colour(input logic [2:0] bar);
    rgb_t c;
    c.red   = {COLOR_W{bar[2]}};
    c.green = {COLOR_W{bar[1]}};
    c.blue  = {COLOR_W{bar[0]}};
    return c;
  endfunction

endpackage

// File: rtl/vga_sync_counter.sv
// Pixel-rate enable, horizontal/vertical position counters and sync/active
// decode for the fixed 640x480@60 mode.
//   board_clock : sole clock
//   rst_n       : asynchronous active-low reset
//   dotclk      : divide-by-2 toggle flop; high means the next edge is a pixel edge
//   h_count     : 0..H_TOTAL-1
//   v_count     : 0..V_TOTAL-1
//   hsync/vsync : active-low sync pulses, decoded from the registered counters
//   active      : high inside the visible 640x480 area
module vga_sync_counter
  import vga_pkg::*;
(
  input  logic   board_clock,
  input  logic   rst_n,
  output logic   dotclk,
  output count_t h_count,
  output count_t v_count,
  output logic   hsync,
  output logic   vsync,
  output logic   active
);

  localparam count_t H_LAST       = count_t'(H_TOTAL - 1);
  localparam count_t V_LAST       = count_t'(V_TOTAL - 1);
  localparam count_t H_SYNC_START = count_t'(H_ACTIVE + H_FP);
  localparam count_t H_SYNC_END   = count_t'(H_ACTIVE + H_FP + H_SYNC);
  localparam count_t V_SYNC_START = count_t'(V_ACTIVE + V_FP);
  localparam count_t V_SYNC_END   = count_t'(V_ACTIVE + V_FP + V_SYNC);
  localparam count_t H_ACT        = count_t'(H_ACTIVE);
  localparam count_t V_ACT        = count_t'(V_ACTIVE);

  logic   dotclk_q, dotclk_d;
  count_t h_count_q, h_count_d;
  count_t v_count_q, v_count_d;
  logic   pix_en;

  // The pixel rate is an enable, not a derived clock: a pixel step happens
  // on the edge where the toggle flop is currently high.
  assign pix_en = dotclk_q;

  always_comb begin
    // NOTE: every _d gets a default before any branch, so no path leaves
    // it unassigned and no latch is inferred.
    dotclk_d  = ~dotclk_q;
    h_count_d = h_count_q;
    v_count_d = v_count_q;
    if (pix_en) begin
      // >= rather than == so a corrupted counter falls back into range.
      if (h_count_q >= H_LAST) begin
        h_count_d = '0;
        v_count_d = (v_count_q >= V_LAST) ? count_t'(0) : v_count_q + count_t'(1);
      end else begin
        h_count_d = h_count_q + count_t'(1);
      end
    end
  end

  always_ff @(posedge board_clock or negedge rst_n) begin
    if (!rst_n) begin
      dotclk_q  <= 1'b0;
      h_count_q <= '0;
      v_count_q <= '0;
    end else begin
      // NOTE: non-blocking so every flop samples pre-edge values and the
      // result does not depend on statement or block ordering.
      dotclk_q  <= dotclk_d;
      h_count_q <= h_count_d;
      v_count_q <= v_count_d;
    end
  end

  assign dotclk  = dotclk_q;
  assign h_count = h_count_q;
  assign v_count = v_count_q;
  assign hsync   = !((h_count_q >= H_SYNC_START) && (h_count_q < H_SYNC_END));
  assign vsync   = !((v_count_q >= V_SYNC_START) && (v_count_q < V_SYNC_END));
  assign active  = (h_count_q < H_ACT) && (v_count_q < V_ACT);

endmodule

// File: rtl/vga.sv
// Fixed-mode 640x480@60 VGA timing and colour-bar test-pattern generator.
//   board_clock, rst_n           : clock and asynchronous active-low reset
//   hsync, vsync                 : active-low sync pulses
//   red, green, blue             : 8-bit colour, 0 outside the active area
//   x_val, y_val                 : active-area coordinate, 0 outside it
//   h_count_test, v_count_test   : raw position counters (bring-up)
//   dotclk_test                  : divide-by-2 pixel-enable toggle (bring-up)
// All outputs are combinational decodes of the counter flops, so they carry
// no extra latency relative to the exported counters.
module vga
  import vga_pkg::*;
(
  input  logic               board_clock,
  input  logic               rst_n,
  output logic               hsync,
  output logic               vsync,
  output logic [COLOR_W-1:0] red,
  output logic [COLOR_W-1:0] green,
  output logic [COLOR_W-1:0] blue,
  output logic [COORD_W-1:0] x_val,
  output logic [COORD_W-1:0] y_val,
  output logic [CNT_W-1:0]   h_count_test,
  output logic [CNT_W-1:0]   v_count_test,
  output logic               dotclk_test
);

  count_t h_count;
  count_t v_count;
  logic   active;
  logic   [2:0] bar;
  rgb_t   colour;

  vga_sync_counter u_sync (
    .board_clock (board_clock),
    .rst_n       (rst_n),
    .dotclk      (dotclk_test),
    .h_count     (h_count),
    .v_count     (v_count),
    .hsync       (hsync),
    .vsync       (vsync),
    .active      (active)
  );

  always_comb begin
    x_val = '0;
    y_val = '0;
    if (active) begin
      x_val = h_count[COORD_W-1:0];
      y_val = v_count[COORD_W-1:0];
    end
  end

  // x_val < 640 inside the active area, so the quotient always fits 3 bits.
  assign bar    = 3'(x_val / COORD_W'(BAR_WIDTH));
  assign colour = active ? bar_colour(bar) : '0;

  assign red          = colour.red;
  assign green        = colour.green;
  assign blue         = colour.blue;
  assign h_count_test = h_count;
  assign v_count_test = v_count;

endmodule

// File: tb/tb_vga.sv
// Self-checking bench for vga: a hand-written vector table for the first
// line, hand sequences for sync widths, line/frame wrap and async reset,
// and a linear-pixel-index reference model checked on every falling edge.
module tb_vga;

  typedef struct packed {
    logic        dot;
    logic [11:0] h;
    logic [11:0] v;
    logic        hs;
    logic        vs;
    logic [9:0]  x;
    logic [9:0]  y;
    logic [7:0]  r;
    logic [7:0]  g;
    logic [7:0]  b;
  } obs_t;

  typedef struct {
    int   edges;
    obs_t exp;
  } vec_t;

  logic        board_clock = 1'b0;
  logic        rst_n       = 1'b0;
  logic        hsync, vsync, dotclk_test;
  logic [7:0]  red, green, blue;
  logic [9:0]  x_val, y_val;
  logic [11:0] h_count_test, v_count_test;

  int n_compared = 0;
  int n_mismatch = 0;
  bit chk_en     = 1'b0;

  // Reference model: a linear pixel index within the frame plus the
  // half-pixel phase; the vertical shift lets the bench jump lines.
  int m_pix    = 0;
  bit m_phase  = 1'b0;
  int m_vshift = 0;

  vga u_dut (
    .board_clock  (board_clock),
    .rst_n        (rst_n),
    .hsync        (hsync),
    .vsync        (vsync),
    .red          (red),
    .green        (green),
    .blue         (blue),
    .x_val        (x_val),
    .y_val        (y_val),
    .h_count_test (h_count_test),
    .v_count_test (v_count_test),
    .dotclk_test  (dotclk_test)
  );

  always #5 board_clock = ~board_clock;

  always @(posedge board_clock or negedge rst_n) begin
    if (!rst_n) begin
      m_pix   <= 0;
      m_phase <= 1'b0;
    end else begin
      if (m_phase) m_pix <= (m_pix + 1) % (800 * 525);
      m_phase <= !m_phase;
    end
  end

  function automatic int cur_h();
    return m_pix % 800;
  endfunction

  function automatic int cur_v();
    return (m_pix / 800 + m_vshift) % 525;
  endfunction

  function automatic obs_t mk_obs(input int dot, input int h, input int v, input int hs,
                                  input int vs, input int x, input int y, input int r,
                                  input int g, input int b);
    obs_t o;
    o.dot = dot[0];  o.h = 12'(h); o.v = 12'(v);
    o.hs  = hs[0];   o.vs = vs[0];
    o.x   = 10'(x);  o.y = 10'(y);
    o.r   = 8'(r);   o.g = 8'(g); o.b = 8'(b);
    return o;
  endfunction

  function automatic obs_t model_obs();
    int  h, v, x, y, bar;
    bit  act;
    h   = cur_h();
    v   = cur_v();
    act = (h < 640) && (v < 480);
    x   = act ? h : 0;
    y   = act ? v : 0;
    bar = x / 80;
    return mk_obs(m_phase, h, v,
                  (h >= 656 && h < 752) ? 0 : 1,
                  (v >= 490 && v < 492) ? 0 : 1,
                  x, y,
                  (act && bar[2]) ? 255 : 0,
                  (act && bar[1]) ? 255 : 0,
                  (act && bar[0]) ? 255 : 0);
  endfunction

  function automatic obs_t dut_obs();
    return mk_obs(dotclk_test, h_count_test, v_count_test, hsync, vsync,
                  x_val, y_val, red, green, blue);
  endfunction

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatch++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge board_clock) begin
    if (chk_en) check("model", 72'(dut_obs()), 72'(model_obs()));
  end

  task automatic run_edges(input int n);
    repeat (n) @(negedge board_clock);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_obs"}, 72'(dut_obs()), 72'(mk_obs(0, 0, 0, 1, 1, 0, 0, 0, 0, 0)));
  endtask

  // Assert reset between edges and check that state clears with no edge.
  task automatic async_reset(input string tag);
    @(negedge board_clock);
    #2 rst_n = 1'b0;
    m_vshift = 0;
    #1 check_reset_state(tag);
    @(negedge board_clock);
    check_reset_state({tag, "_held"});
    #1 rst_n = 1'b1;
  endtask

  // Jump the DUT's vertical counter and keep the model in step.
  task automatic deposit_v(input int v);
    @(negedge board_clock);
    #1;
    u_dut.u_sync.v_count_q = 12'(v);
    m_vshift = (v - m_pix / 800 + 525) % 525;
  endtask

  vec_t vecs[$];

  initial begin
    int low_cnt;
    bit found;

    // Edge count after release -> expected outputs for the first line.
    vecs.push_back('{10,   mk_obs(0,   5, 0, 1, 1,   5, 0,   0,   0,   0)});
    vecs.push_back('{160,  mk_obs(0,  80, 0, 1, 1,  80, 0,   0,   0, 255)});
    vecs.push_back('{322,  mk_obs(0, 161, 0, 1, 1, 161, 0,   0, 255,   0)});
    vecs.push_back('{800,  mk_obs(0, 400, 0, 1, 1, 400, 0, 255,   0, 255)});
    vecs.push_back('{1278, mk_obs(0, 639, 0, 1, 1, 639, 0, 255, 255, 255)});
    vecs.push_back('{1280, mk_obs(0, 640, 0, 1, 1,   0, 0,   0,   0,   0)});
    vecs.push_back('{1311, mk_obs(1, 655, 0, 1, 1,   0, 0,   0,   0,   0)});
    vecs.push_back('{1312, mk_obs(0, 656, 0, 0, 1,   0, 0,   0,   0,   0)});
    vecs.push_back('{1503, mk_obs(1, 751, 0, 0, 1,   0, 0,   0,   0,   0)});
    vecs.push_back('{1504, mk_obs(0, 752, 0, 1, 1,   0, 0,   0,   0,   0)});
    vecs.push_back('{1599, mk_obs(1, 799, 0, 1, 1,   0, 0,   0,   0,   0)});
    vecs.push_back('{1600, mk_obs(0,   0, 1, 1, 1,   0, 1,   0,   0,   0)});
    vecs.push_back('{1602, mk_obs(0,   1, 1, 1, 1,   1, 1,   0,   0,   0)});

    // Reset state.
    #23;
    check_reset_state("reset");
    @(negedge board_clock);
    #1 rst_n = 1'b1;
    chk_en = 1'b1;

    // dotclk alternates 1,0,1,... over the first ten edges.
    for (int i = 1; i <= 10; i++) begin
      run_edges(1);
      check($sformatf("dotclk_e%0d", i), 72'(dotclk_test), 72'(i % 2));
    end

    // Vector table across the first line and the line wrap.
    begin
      int done = 10;
      for (int i = 0; i < vecs.size(); i++) begin
        run_edges(vecs[i].edges - done);
        done = vecs[i].edges;
        check($sformatf("vec%0d_e%0d", i, vecs[i].edges), 72'(dut_obs()), 72'(vecs[i].exp));
      end
    end

    // hsync is low for 192 board clocks in any one-line window.
    low_cnt = 0;
    for (int i = 0; i < 1600; i++) begin
      run_edges(1);
      if (!hsync) low_cnt++;
    end
    check("hsync_width", 72'(low_cnt), 72'(192));

    // vsync is low for exactly lines 490 and 491 across lines 488..491.
    deposit_v(488);
    low_cnt = 0;
    for (int i = 0; i < 6400; i++) begin
      run_edges(1);
      if (!vsync) low_cnt++;
    end
    check("vsync_width", 72'(low_cnt), 72'(3200));

    // Frame wrap from (799, 524) back to (0, 0).
    deposit_v(524);
    found = 1'b0;
    for (int i = 0; i < 4000 && !found; i++) begin
      run_edges(1);
      if (m_phase && cur_h() == 799 && cur_v() == 524) found = 1'b1;
    end
    check("wrap_reached", 72'(found), 72'(1));
    check("pre_wrap_hv", 72'({h_count_test, v_count_test}), 72'({12'd799, 12'd524}));
    run_edges(1);
    check("post_wrap", 72'(dut_obs()), 72'(mk_obs(0, 0, 0, 1, 1, 0, 0, 0, 0, 0)));

    // Mid-line reset at h_count = 300.
    async_reset("restart");
    run_edges(600);
    check("h300", 72'({h_count_test, v_count_test}), 72'({12'd300, 12'd0}));
    async_reset("midline");
    run_edges(3);
    check("restart_h1", 72'({dotclk_test, h_count_test}), 72'({1'b1, 12'd1}));

    // Randomised: random line jumps, run lengths and mid-frame resets,
    // with the per-edge model check running throughout.
    for (int it = 0; it < 6; it++) begin
      deposit_v(int'($urandom_range(0, 524)));
      run_edges(int'($urandom_range(50, 3000)));
      if ($urandom_range(0, 1) == 1) async_reset($sformatf("rand_rst%0d", it));
    end

    @(negedge board_clock);
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
    $finish;
  end

endmodule
